// File: rtl/md5_msg_packer.sv
// Byte-stream front end for the pancham MD5 core: packs up to 16 bytes into msg_in,
// issues one msg_in_valid pulse per message and holds off until the core is finished.
module md5_msg_packer #(
  parameter int WAIT_DONE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_keep,
  input  logic         byte_last,
  output logic         byte_ready,
  output logic [0:127] msg_in,
  output logic [0:7]   msg_in_width,
  output logic         msg_in_valid,
  input  logic         core_ready,
  input  logic         core_done,
  output logic         ovf_err,
  output logic         busy
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] DISCARD = 2'd1;
  localparam logic [1:0] ARM     = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  logic [1:0] state;
  logic [4:0] cnt;
  logic       seen_low;
  logic       accept;
  logic       full;

  assign byte_ready   = ~reset & ((state == COLLECT) | (state == DISCARD));
  assign accept       = byte_valid & byte_ready;
  assign full         = cnt[4];
  assign msg_in_width = {cnt, 3'b000};
  assign busy         = (state != COLLECT) | (cnt != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= COLLECT;
      cnt          <= 5'd0;
      msg_in       <= '0;
      msg_in_valid <= 1'b0;
      ovf_err      <= 1'b0;
      seen_low     <= 1'b0;
    end else begin
      msg_in_valid <= 1'b0;
      ovf_err      <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (byte_keep && !full) begin
              // First kept byte lands in the last octet so it ends up at the LSB end
              for (int k = 0; k < 16; k++) begin
                if (cnt[3:0] == 4'(k)) msg_in[120-8*k +: 8] <= byte_in;
              end
              cnt <= cnt + 5'd1;
              if (byte_last) state <= ARM;
            end else if (byte_keep) begin
              if (byte_last) begin
                ovf_err <= 1'b1;
                msg_in  <= '0;
                cnt     <= 5'd0;
              end else begin
                state <= DISCARD;
              end
            end else if (byte_last) begin
              state <= ARM;
            end
          end
        end
        DISCARD: begin
          if (accept && byte_last) begin
            ovf_err <= 1'b1;
            msg_in  <= '0;
            cnt     <= 5'd0;
            state   <= COLLECT;
          end
        end
        ARM: begin
          if (core_ready) begin
            msg_in_valid <= 1'b1;
            seen_low     <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // Without core_done, completion is inferred from ready dropping and returning
          if (WAIT_DONE != 0) begin
            if (core_done) begin
              msg_in <= '0;
              cnt    <= 5'd0;
              state  <= COLLECT;
            end
          end else begin
            if (!core_ready) begin
              seen_low <= 1'b1;
            end else if (seen_low) begin
              msg_in <= '0;
              cnt    <= 5'd0;
              state  <= COLLECT;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
